imem_loader: RTL and testbench

Writer-side counterpart of the instruction memory. Takes a byte stream (e.g. from a UART receiver), packs it little-endian into 32-bit instructions, and drives the instruction memory write port at consecutive word-aligned addresses. While loading, it holds the CPU via cpu_hold so the core does not fetch partially written code.

---
 rtl/imem_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes
// them to consecutive word addresses of the instruction memory, holding the
// CPU while a session is in progress.
//
// Session byte stream: one count byte N (0 means 256, clamped to DEPTH),
// then 4*N data bytes, then (checksum build only) one XOR checksum byte.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds CHK state and err).
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   start     in   one-cycle pulse, begins a session from IDLE
//   in_valid  in   in_data holds a valid byte
//   in_data   in   [7:0] stream byte
//   in_ready  out  byte accepted this cycle when in_valid is also 1
//   im_we     out  one-cycle write pulse per word
//   im_waddr  out  [31:0] byte address of the write (word aligned)
//   im_wdata  out  [31:0] word to write
//   busy      out  session in progress
//   done      out  sticky, last session completed
//   cpu_hold  out  hold the CPU in reset while 1
//   err       out  sticky checksum error (0 without the checksum feature)
module imem_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_waddr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        done,
  output logic        cpu_hold,
  output logic        err
);

  localparam int unsigned   IDX_W   = 9;
  localparam logic [IDX_W-1:0] DEPTH_N = IDX_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_FINISH
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_e;

  state_e state_q, state_d;

  logic             in_ready_q, in_ready_d;
  logic             im_we_q, im_we_d;
  logic [31:0]      im_waddr_q, im_waddr_d;
  logic [31:0]      im_wdata_q, im_wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      asm_q, asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic             err_q, err_d;
  logic [7:0]       chk_q, chk_d;
`endif

  logic             xfer_c;
  logic [IDX_W-1:0] cnt_c;
  logic             last_word_c;

  assign xfer_c      = in_valid & in_ready_q;
  // A count byte of zero encodes 256 words.
  assign cnt_c       = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
  assign last_word_c = ((word_idx_q + 9'd1) == n_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_COUNT;
      S_COUNT:  if (xfer_c) state_d = S_DATA;
      S_DATA:   if (xfer_c && (byte_idx_q == 2'd3)) state_d = S_WRITE;
      S_WRITE: begin
        if (last_word_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_FINISH;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:    if (xfer_c) state_d = S_FINISH;
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are registered from the next state
  always_comb begin
    in_ready_d = 1'b0;
    im_we_d    = 1'b0;
    im_waddr_d = im_waddr_q;
    im_wdata_d = im_wdata_q;
    busy_d     = (state_d != S_IDLE) && (state_d != S_FINISH);
    cpu_hold_d = (state_d != S_IDLE) && (state_d != S_FINISH);
    done_d     = done_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    err_d      = err_q;
    chk_d      = chk_q;
    in_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CHK);
`else
    in_ready_d = (state_d == S_COUNT) || (state_d == S_DATA);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          word_idx_d = '0;
          byte_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          err_d      = 1'b0;
          chk_d      = '0;
`endif
        end
      end
      S_COUNT: begin
        if (xfer_c) n_d = (cnt_c > DEPTH_N) ? DEPTH_N : cnt_c;
      end
      S_DATA: begin
        if (xfer_c) begin
          asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d      = chk_q ^ in_data;
`endif
          // Last byte goes straight into the write register alongside asm_q.
          if (byte_idx_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_waddr_d = BASE_ADDR + {21'd0, word_idx_q, 2'b00};
            im_wdata_d = {in_data, asm_q[23:0]};
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 9'd1;
        byte_idx_d = '0;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (xfer_c && (in_data != chk_q)) err_d = 1'b1;
      end
`endif
      default: ;
    endcase

    if (state_d == S_FINISH) done_d = 1'b1;
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_waddr_q <= '0;
      im_wdata_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cpu_hold_q <= 1'b0;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
      chk_q      <= '0;
`endif
    end else begin
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_waddr_q <= im_waddr_d;
      im_wdata_q <= im_wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cpu_hold_q <= cpu_hold_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q      <= err_d;
      chk_q      <= chk_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_waddr = im_waddr_q;
  assign im_wdata = im_wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cpu_hold = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte sessions, scoreboard of expected writes.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, im_we, busy, done, cpu_hold, err;
  logic [31:0] im_waddr, im_wdata;

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .busy(busy), .done(done), .cpu_hold(cpu_hold), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, 32'(act), 32'(exp));
  endtask

  // Monitor: every write pulse must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (im_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected write: addr %h data %h", im_waddr, im_wdata);
        end else begin
          e = exp_q.pop_front();
          check32("write addr", im_waddr, e.addr);
          check32("write data", im_wdata, e.data);
          check1("in_ready during write", in_ready, 1'b0);
        end
      end
    end
  end

  // Present one byte after a random idle gap; returns at the negedge after transfer.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int guard;
    bit ok;
    guard = 0;
    in_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = in_ready;
    while (!ok && guard < 50) begin
      @(negedge clk);
      ok = in_ready;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!ok) check1("in_ready timeout", 1'b0, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full session: model decides word count, addresses and words.
  task automatic run_session(input logic [7:0] cnt, input bit fixed, input bit bad_chk,
                             input bit poke, input int max_gap);
    int         n;
    int         g;
    logic [7:0] b[4];
    logic [7:0] lit[4];
    logic [7:0] x;
    logic       exp_err;
    wr_t        e;
    lit[0] = 8'h13; lit[1] = 8'h05; lit[2] = 8'h10; lit[3] = 8'h00;
    x = 8'h00;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    if (n > int'(DEPTH)) n = int'(DEPTH);
    pulse_start();
    check1("busy after start", busy, 1'b1);
    check1("cpu_hold after start", cpu_hold, 1'b1);
    check1("done cleared by start", done, 1'b0);
    send_byte(cnt, max_gap);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) b[k] = fixed ? lit[k] : 8'($urandom);
      e.addr = BASE + 32'(4 * i);
      e.data = {b[3], b[2], b[1], b[0]};
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        x = x ^ b[k];
        send_byte(b[k], max_gap);
        if (poke && i == 0 && k == 1) pulse_start();
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, max_gap);
    exp_err = bad_chk;
`else
    exp_err = 1'b0;
`endif
    g = 0;
    while (done !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check1("done at finish", done, 1'b1);
    check1("busy at finish", busy, 1'b0);
    check1("cpu_hold at finish", cpu_hold, 1'b0);
    check1("err at finish", err, exp_err);
    check32("writes outstanding", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check1("done sticky", done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    check1("reset in_ready", in_ready, 1'b0);
    check1("reset im_we", im_we, 1'b0);
    check32("reset im_waddr", im_waddr, 32'h0);
    check32("reset im_wdata", im_wdata, 32'h0);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset cpu_hold", cpu_hold, 1'b0);
    check1("reset err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single known word
    run_session(8'h01, 1'b1, 1'b0, 1'b0, 0);

    // Bytes offered in IDLE are not consumed
    in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("idle in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;

    // Three words with random gaps
    run_session(8'h03, 1'b0, 1'b0, 1'b0, 3);
    // start pulsed mid-session is ignored
    run_session(8'h02, 1'b0, 1'b0, 1'b1, 2);
    for (int s = 0; s < 4; s++) run_session(8'($urandom_range(1, 8)), 1'b0, 1'b0, 1'b0, 3);
    // Count 0 means 256 words
    run_session(8'h00, 1'b0, 1'b0, 1'b0, 0);

    // Reset mid-session after two data bytes
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    rst = 1'b1;
    @(negedge clk);
    check1("abort in_ready", in_ready, 1'b0);
    check1("abort im_we", im_we, 1'b0);
    check32("abort im_waddr", im_waddr, 32'h0);
    check32("abort im_wdata", im_wdata, 32'h0);
    check1("abort busy", busy, 1'b0);
    check1("abort done", done, 1'b0);
    check1("abort cpu_hold", cpu_hold, 1'b0);
    check1("abort err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    run_session(8'h01, 1'b0, 1'b0, 1'b0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_session(8'h01, 1'b1, 1'b0, 1'b0, 0);
    run_session(8'h01, 1'b1, 1'b1, 1'b0, 0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
